// File: rtl/key_event_sched.sv
// Turns debounced key levels into PRESS/RELEASE/LONG/REPEAT events, arbitrates
// pending events round-robin into a small show-ahead FIFO drained over valid/ready.
module key_event_sched #(
  parameter int          N_KEYS       = 4,
  parameter logic [15:0] TICK_DIV     = 16'd1000,
  parameter logic [15:0] LONG_TICKS   = 16'd1000,
  parameter logic [15:0] REPEAT_TICKS = 16'd200,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_i,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [2:0]        evt_key,
  output logic [1:0]        evt_code,
  output logic              ovf_o,
  input  logic              ovf_clr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG} key_st_e;
  typedef enum logic [1:0] {
    EV_PRESS   = 2'b00,
    EV_RELEASE = 2'b01,
    EV_LONG    = 2'b10,
    EV_REPEAT  = 2'b11
  } ev_code_e;

  // Timing tick prescaler
  logic [15:0] tick_cnt;
  logic        tick;

  assign tick = (tick_cnt == TICK_DIV - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 16'd1;
  end

  // Edge detection against the previous sampled level
  logic [N_KEYS-1:0] key_q, rise, fall;

  assign rise = key_i & ~key_q;
  assign fall = ~key_i & key_q;

  // Per-key state machines
  key_st_e           st_q   [N_KEYS];
  key_st_e           st_d   [N_KEYS];
  logic [15:0]       hold_q [N_KEYS];
  logic [15:0]       hold_d [N_KEYS];
  logic [N_KEYS-1:0] raise;
  ev_code_e          raise_code [N_KEYS];

  // NOTE: combinational blocks use blocking assignments and give every output a
  // default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    for (int k = 0; k < N_KEYS; k++) begin
      st_d[k]       = st_q[k];
      hold_d[k]     = hold_q[k];
      raise[k]      = 1'b0;
      raise_code[k] = EV_PRESS;
      case (st_q[k])
        ST_IDLE: begin
          if (rise[k]) begin
            raise[k]      = 1'b1;
            raise_code[k] = EV_PRESS;
            st_d[k]       = ST_HELD;
            hold_d[k]     = '0;
          end
        end
        ST_HELD, ST_LONG: begin
          // A release on a threshold edge suppresses the LONG/REPEAT event.
          if (fall[k]) begin
            raise[k]      = 1'b1;
            raise_code[k] = EV_RELEASE;
            st_d[k]       = ST_IDLE;
            hold_d[k]     = '0;
          end else if (tick) begin
            if (st_q[k] == ST_HELD && hold_q[k] + 16'd1 == LONG_TICKS) begin
              raise[k]      = 1'b1;
              raise_code[k] = EV_LONG;
              st_d[k]       = ST_LONG;
              hold_d[k]     = '0;
            end else if (st_q[k] == ST_LONG && hold_q[k] + 16'd1 == REPEAT_TICKS) begin
              raise[k]      = 1'b1;
              raise_code[k] = EV_REPEAT;
              hold_d[k]     = '0;
            end else begin
              hold_d[k] = hold_q[k] + 16'd1;
            end
          end
        end
        default: st_d[k] = ST_IDLE;
      endcase
    end
  end

  // Pending slots, arbiter and FIFO handshake
  logic [N_KEYS-1:0] slot_v;
  logic [1:0]        slot_code [N_KEYS];
  logic [N_KEYS-1:0] drop;
  logic [7:0]        slot_v_pad;
  logic [2:0]        rr_ptr;
  logic [2:0]        grant_idx;
  logic              grant_v;
  logic [3:0]        cand;
  logic [PW:0]       wr_ptr, rd_ptr;
  logic              full, empty, push, pop;

  assign drop       = raise & slot_v;
  assign slot_v_pad = 8'(slot_v);

  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      cand = {1'b0, rr_ptr} + 4'(i);
      if (cand >= 4'(N_KEYS)) cand = cand - 4'(N_KEYS);
      if (!grant_v && slot_v_pad[cand[2:0]]) begin
        grant_v   = 1'b1;
        grant_idx = cand[2:0];
      end
    end
  end

  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  // Push is decided on the current occupancy; a same-cycle pop does not free a slot.
  assign push  = grant_v && !full;
  assign pop   = !empty && evt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q  <= '0;
      slot_v <= '0;
      rr_ptr <= '0;
      ovf_o  <= 1'b0;
      for (int k = 0; k < N_KEYS; k++) begin
        st_q[k]      <= ST_IDLE;
        hold_q[k]    <= '0;
        slot_code[k] <= '0;
      end
    end else begin
      key_q <= key_i;
      for (int k = 0; k < N_KEYS; k++) begin
        st_q[k]   <= st_d[k];
        hold_q[k] <= hold_d[k];
        if (push && grant_idx == 3'(k)) slot_v[k] <= 1'b0;
        if (raise[k] && !slot_v[k]) begin
          slot_v[k]    <= 1'b1;
          slot_code[k] <= raise_code[k];
        end
      end
      if (push) rr_ptr <= (grant_idx == 3'(N_KEYS - 1)) ? 3'd0 : grant_idx + 3'd1;
      if (|drop)        ovf_o <= 1'b1;
      else if (ovf_clr) ovf_o <= 1'b0;
    end
  end

  // Event FIFO storage
  logic [2:0] mem_key  [FIFO_DEPTH];
  logic [1:0] mem_code [FIFO_DEPTH];

  // NOTE: the storage array has no reset; only the pointers do. Entries are never
  // read before being written, and the outputs are forced to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_key[wr_ptr[PW-1:0]]  <= grant_idx;
      mem_code[wr_ptr[PW-1:0]] <= slot_code[grant_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign evt_valid = !empty;
  assign evt_key   = evt_valid ? mem_key[rd_ptr[PW-1:0]]  : 3'd0;
  assign evt_code  = evt_valid ? mem_code[rd_ptr[PW-1:0]] : 2'd0;

endmodule

// File: tb/tb_key_event_sched.sv
// Directed bench for key_event_sched: table-driven press/release/fairness vectors,
// then hand sequences for long/repeat timing, backpressure, overflow and reset.
module tb_key_event_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_i = '0;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       evt_valid;
  logic [2:0] evt_key;
  logic [1:0] evt_code;
  logic       ovf_o;

  always #5 clk = ~clk;

  key_event_sched #(
    .N_KEYS(4), .TICK_DIV(16'd4), .LONG_TICKS(16'd5),
    .REPEAT_TICKS(16'd3), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_i(key_i),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_key(evt_key), .evt_code(evt_code),
    .ovf_o(ovf_o), .ovf_clr(ovf_clr)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Observed outputs packed as {valid, key[2:0], code[1:0], ovf}
  function automatic logic [6:0] obs_pack(input logic v, input logic [2:0] k,
                                          input logic [1:0] c, input logic o);
    return {v, k, c, o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input logic [3:0] k, input logic rdy, input logic clr);
    key_i = k; evt_ready = rdy; ovf_clr = clr;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; key_i = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] key;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [30];

  function automatic vec_t mk(input logic [3:0] k, input logic v,
                              input logic [2:0] ek, input logic [1:0] ec);
    vec_t r;
    r.key = k;
    r.exp = {v, ek, ec, 1'b0};
    return r;
  endfunction

  int         ev_cyc  [$];
  logic [2:0] ev_key  [$];
  logic [1:0] ev_code [$];

  // Hold key 1 for edges 1..hold, release afterwards, log every head seen (ready=1).
  task automatic run_hold(input int hold, input int total);
    ev_cyc.delete(); ev_key.delete(); ev_code.delete();
    for (int c = 1; c <= total; c++) begin
      step((c <= hold) ? 4'b0010 : 4'b0000, 1'b1, 1'b0);
      if (evt_valid) begin
        ev_cyc.push_back(c);
        ev_key.push_back(evt_key);
        ev_code.push_back(evt_code);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cyc [5];
    logic [1:0] exp_code [5];

    // Fairness bursts, single press/release, RR pointer carry-over (ready=1).
    vecs[0]  = mk(4'b1111, 0, 0, 0);
    vecs[1]  = mk(4'b1111, 1, 0, 0);
    vecs[2]  = mk(4'b1111, 1, 1, 0);
    vecs[3]  = mk(4'b1111, 1, 2, 0);
    vecs[4]  = mk(4'b1111, 1, 3, 0);
    vecs[5]  = mk(4'b1111, 0, 0, 0);
    vecs[6]  = mk(4'b0000, 0, 0, 0);
    vecs[7]  = mk(4'b0000, 1, 0, 1);
    vecs[8]  = mk(4'b0000, 1, 1, 1);
    vecs[9]  = mk(4'b0000, 1, 2, 1);
    vecs[10] = mk(4'b0000, 1, 3, 1);
    vecs[11] = mk(4'b0000, 0, 0, 0);
    vecs[12] = mk(4'b0100, 0, 0, 0);
    vecs[13] = mk(4'b0100, 1, 2, 0);
    vecs[14] = mk(4'b0100, 0, 0, 0);
    vecs[15] = mk(4'b0000, 0, 0, 0);
    vecs[16] = mk(4'b0000, 1, 2, 1);
    vecs[17] = mk(4'b0000, 0, 0, 0);
    vecs[18] = mk(4'b1111, 0, 0, 0);
    vecs[19] = mk(4'b1111, 1, 3, 0);
    vecs[20] = mk(4'b1111, 1, 0, 0);
    vecs[21] = mk(4'b1111, 1, 1, 0);
    vecs[22] = mk(4'b1111, 1, 2, 0);
    vecs[23] = mk(4'b1111, 0, 0, 0);
    vecs[24] = mk(4'b0000, 0, 0, 0);
    vecs[25] = mk(4'b0000, 1, 3, 1);
    vecs[26] = mk(4'b0000, 1, 0, 1);
    vecs[27] = mk(4'b0000, 1, 1, 1);
    vecs[28] = mk(4'b0000, 1, 2, 1);
    vecs[29] = mk(4'b0000, 0, 0, 0);

    do_reset();
    check("reset_outputs", 32'(obs_pack(evt_valid, evt_key, evt_code, ovf_o)), 32'd0);
    for (int i = 0; i < 30; i++) begin
      step(vecs[i].key, 1'b1, 1'b0);
      check($sformatf("vec%0d", i), 32'(obs_pack(evt_valid, evt_key, evt_code, ovf_o)),
            32'(vecs[i].exp));
    end

    // Long press and repeat with exact tick phase from reset (tick at edges 4,8,..).
    exp_cyc  = '{2, 21, 33, 45, 52};
    exp_code = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b01};
    do_reset();
    run_hold(50, 70);
    check("long_event_count", 32'(ev_cyc.size()), 32'd5);
    if (ev_cyc.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("long_cyc%0d", i), 32'(ev_cyc[i]), 32'(exp_cyc[i]));
        check($sformatf("long_code%0d", i), 32'(ev_code[i]), 32'(exp_code[i]));
        check($sformatf("long_key%0d", i), 32'(ev_key[i]), 32'd1);
      end
    end

    // Release on the edge where LONG would fire (edge 20): only PRESS and RELEASE.
    do_reset();
    run_hold(19, 35);
    check("thr_event_count", 32'(ev_cyc.size()), 32'd2);
    if (ev_cyc.size() == 2) begin
      check("thr_press_code", 32'(ev_code[0]), 32'd0);
      check("thr_release_code", 32'(ev_code[1]), 32'd1);
      check("thr_release_cyc", 32'(ev_cyc[1]), 32'd21);
    end

    // Backpressure with a 2-entry FIFO, then a dropped RELEASE.
    do_reset();
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    check("bp_full_head", 32'(obs_pack(evt_valid, evt_key, evt_code, ovf_o)),
          32'(obs_pack(1, 0, 0, 0)));
    step(4'b1011, 1'b0, 1'b0);
    check("bp_drop_sets_ovf", 32'(obs_pack(evt_valid, evt_key, evt_code, ovf_o)),
          32'(obs_pack(1, 0, 0, 1)));
    for (int i = 1; i <= 3; i++) begin
      step(4'b1011, 1'b1, 1'b0);
      check($sformatf("drain_head%0d", i), 32'(obs_pack(evt_valid, evt_key, evt_code, ovf_o)),
            32'(obs_pack(1, 3'(i), 0, 1)));
    end
    step(4'b1011, 1'b1, 1'b0);
    check("drain_empty", 32'(obs_pack(evt_valid, evt_key, evt_code, ovf_o)),
          32'(obs_pack(0, 0, 0, 1)));

    // Clear and drop on the same edge: the set wins; a later lone clear works.
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b1);
    check("ovf_set_wins", 32'(obs_pack(evt_valid, evt_key, evt_code, ovf_o)),
          32'(obs_pack(1, 0, 1, 1)));
    step(4'b1000, 1'b0, 1'b1);
    check("ovf_clear", 32'(obs_pack(evt_valid, evt_key, evt_code, ovf_o)),
          32'(obs_pack(1, 0, 1, 0)));

    // Reset in the middle of a hold with a full FIFO and ovf set.
    do_reset();
    step(4'b0011, 1'b0, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    step(4'b0111, 1'b0, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    check("pre_reset_state", 32'(obs_pack(evt_valid, evt_key, evt_code, ovf_o)),
          32'(obs_pack(1, 0, 0, 1)));
    key_i = 4'b0001;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_clears", 32'(obs_pack(evt_valid, evt_key, evt_code, ovf_o)), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(4'b0001, 1'b0, 1'b0);
    check("post_reset_edge1", 32'(obs_pack(evt_valid, evt_key, evt_code, ovf_o)), 32'd0);
    step(4'b0001, 1'b0, 1'b0);
    check("post_reset_press", 32'(obs_pack(evt_valid, evt_key, evt_code, ovf_o)),
          32'(obs_pack(1, 0, 0, 0)));
    step(4'b0001, 1'b1, 1'b0);
    check("post_reset_pop", 32'(obs_pack(evt_valid, evt_key, evt_code, ovf_o)), 32'd0);
    step(4'b0001, 1'b1, 1'b0);
    check("post_reset_single", 32'(obs_pack(evt_valid, evt_key, evt_code, ovf_o)), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/key_event_sched.md
Name: key_event_sched

Overview:
- Controller for a bank of debouncer outputs. Turns N debounced key levels into timed key events: press, release, long-press and auto-repeat.
- Round-robin arbitration decides which key's pending event is queued next; events go into a small FIFO.
- The FIFO drains over a valid/ready interface toward the host/UI logic.
- Sits directly after the per-key debouncers in the board-level input path.

Parameters:
- N_KEYS, 4, number of keys; range 1..8.
- TICK_DIV, 16'd1000, clk cycles per timing tick (1 ms at 1 MHz).
- LONG_TICKS, 16'd1000, ticks of continuous hold before a LONG event.
- REPEAT_TICKS, 16'd200, ticks between REPEAT events after LONG.
- FIFO_DEPTH, 4, event FIFO entries; power of 2, range 2..16.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset.
- key_i  input  N_KEYS  debounced key levels; 1 = pressed; synchronous to clk.
- evt_valid  output  1  FIFO head holds an event.
- evt_ready  input  1  consumer accepts head when evt_valid & evt_ready at a clk edge.
- evt_key  output  3  key index of head event.
- evt_code  output  2  head event type: 00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT.
- ovf_o  output  1  sticky: an event was dropped.
- ovf_clr  input  1  clears ovf_o.

Behaviour:
- Interface decision: clock clk; reset rst_n, asynchronous, active-low.
- Reset values:
  - Outputs: evt_valid=0, evt_key=0, evt_code=0, ovf_o=0.
  - Internal: all key_q=0, key states IDLE, hold counters 0, pending slots empty, RR pointer 0, FIFO empty, tick prescaler 0.
- Tick prescaler:
  - Free-running from 0 to TICK_DIV-1.
  - tick pulses for 1 clk when the prescaler is at TICK_DIV-1, then wraps to 0.
- Per-key registers:
  - key_q[k] <= key_i[k] every clk.
  - Rise = key_i & ~key_q; fall = ~key_i & key_q. Both are evaluated on the same edge that updates key_q.
- Per-key FSM (states IDLE, HELD, LONG) with a 16-bit hold counter:
  - IDLE, rise: raise PRESS; go to HELD; counter=0.
  - HELD, on tick: counter+1. When counter+1 == LONG_TICKS: raise LONG; go to LONG; counter=0.
  - LONG, on tick: counter+1. When counter+1 == REPEAT_TICKS: raise REPEAT; counter=0.
  - HELD or LONG, fall: raise RELEASE; go to IDLE; counter=0.
  - Fall and threshold on the same edge: fall wins; only RELEASE is raised.
- Pending slots:
  - Each key has one pending slot holding {valid, code}.
  - A raised event fills an empty slot.
  - If the slot is still full (including full on the same edge it is being granted), the new event is dropped and ovf_o <= 1.
- Arbiter:
  - Combinational round-robin over valid slots, starting at the RR pointer.
  - Grant happens only when the FIFO is not full. The push-enable decision does not count a same-cycle pop.
  - On grant: push {key, code} into the FIFO, clear that slot, RR pointer <= granted index + 1 (mod N_KEYS).
  - At most one push per cycle.
- FIFO:
  - Show-ahead; evt_* reflect the head entry.
  - evt_valid = not empty.
  - Pop on evt_valid & evt_ready.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH; an extra wrap bit distinguishes full from empty.
- Latency: key_i high sampled at edge E0 → slot filled at E0 → pushed at E1 → evt_valid=1 after E1, provided the FIFO and arbiter are idle.
- Overflow flag:
  - ovf_o stays set until ovf_clr is high at a clk edge.
  - If a set and a clear occur on the same edge, set wins.
- Reset mid-operation:
  - All state is discarded immediately, including queued events.
  - A key held through reset has key_q=0 afterwards, so it produces a fresh PRESS 2 cycles after rst_n deasserts.
- Unused upper evt_key bits are 0 when N_KEYS < 8.

Test Plan:
- Single press: key_i[2] 0→1 at E0, evt_ready=1 → evt_valid=1 after E1 with evt_key=2, code=00; popped next edge. Release → code=01, same 2-cycle latency.
- Long/repeat: TICK_DIV=4, LONG_TICKS=5, REPEAT_TICKS=3. Hold key 1 for 40 clk → PRESS, LONG about 20 clk after press, then REPEAT every 12 clk (±1 tick on the first). Release → RELEASE; no further events.
- Fairness: all 4 keys rise on the same edge with evt_ready=1 → pushes on 4 consecutive cycles, key order 0,1,2,3. Next simultaneous burst starts from the post-burst RR pointer.
- Backpressure/overflow: FIFO_DEPTH=2, evt_ready=0, 4 keys press.
  - FIFO holds keys 0 and 1; keys 2 and 3 stay pending, ovf_o=0.
  - Releasing key 2 while its PRESS is pending drops the RELEASE and sets ovf_o=1.
  - Raising evt_ready drains 4 entries in RR order.
- Boundary: release on the same edge the LONG threshold is reached → only RELEASE is queued. ovf_clr and a drop on the same edge → ovf_o stays 1.
- Reset mid-hold: assert rst_n=0 with 2 events queued and key 0 held → evt_valid=0 immediately, ovf_o=0. After deassert, a single PRESS for key 0 with evt_valid=1 after 2 edges.
